tff_sync_down_timer: RTL



---
 rtl/tff_sync_down_timer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/tff_sync_down_timer.sv
// Loadable synchronous down timer built from T-type count bits, with terminal-count pulse,
// auto-reload and IDLE/RUN/DONE run control. Define TIMER_PRESCALE_EN to divide the count tick by PRESCALE.
module tff_sync_down_timer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rel_q, rel_d;
  logic [WIDTH-1:0] t_en;
  logic             borrow;
  logic             tc_d;
  logic             tick;
  logic             is_run;

  if (PRESCALE < 2) begin : g_prescale_chk
    $error("PRESCALE must be >= 2");
  end

  assign is_run = (state_q == ST_RUN);

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PW = $clog2(PRESCALE);

  logic [PW-1:0] pre_q, pre_d;

  // Tick on the PRESCALE-th RUN cycle; any control event or non-RUN cycle restarts the divider.
  assign tick = is_run && (pre_q == PW'(PRESCALE - 1));

  always_comb begin
    pre_d = pre_q + PW'(1);
    if (load || stop || start || !is_run || tick) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = is_run;
`endif

  // Bit i toggles when every lower bit is zero; suppressed at zero so the count never wraps.
  always_comb begin
    t_en   = '0;
    borrow = tick && (cnt_q != '0);
    for (int i = 0; i < int'(WIDTH); i++) begin
      t_en[i] = borrow;
      borrow  = borrow & ~cnt_q[i];
    end
  end

  // Control priority: load > stop > start > counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    tc_d    = 1'b0;
    if (load) begin
      cnt_d = load_val;
      rel_d = load_val;
      if (stop || !is_run) begin
        state_d = ST_IDLE;
      end
    end else if (stop) begin
      if (is_run) begin
        state_d = ST_IDLE;
      end
    end else if (start && !is_run) begin
      state_d = ST_RUN;
      if (state_q == ST_DONE) begin
        cnt_d = rel_q;
      end
    end else if (tick) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q ^ t_en;
      end else begin
        tc_d = 1'b1;
        if (auto_reload) begin
          cnt_d = rel_q;
        end else begin
          state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rel_q   <= '0;
      tc      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      tc      <= tc_d;
      busy    <= (state_d == ST_RUN);
      done    <= (state_d == ST_DONE);
    end
  end

  assign q    = cnt_q;
  assign qbar = ~cnt_q;

endmodule
